// File: rtl/adc_fifo_stream_sequencer_if.sv
// Bundle of FIFO read-port, host byte-stream and status signals for the
// streaming ADC FIFO sequencer. The master side is the sequencer itself.
interface adc_fifo_stream_sequencer_if #(
    parameter int unsigned pLEVEL_WIDTH  = 18,
    parameter int unsigned pTHRESH_WIDTH = 17
);
    logic                     stream_enable;
    logic [pTHRESH_WIDTH-1:0] stream_segment_threshold;
    logic                     fifo_empty;
    logic [pLEVEL_WIDTH-1:0]  fifo_level;
    logic [7:0]               fifo_data;
    logic                     fifo_rd_en;
    logic                     host_req;
    logic [7:0]               host_data;
    logic                     host_data_valid;
    logic                     segment_ready;
    logic                     segment_ack;
    logic                     clear_errors;
    logic                     no_underflow_errors;
    logic [7:0]               underflow_count;
    logic                     underflow_err;
    logic [31:0]              bytes_read;
    logic                     busy;

    modport master (
        input  stream_enable, stream_segment_threshold, fifo_empty, fifo_level, fifo_data,
               host_req, segment_ack, clear_errors, no_underflow_errors,
        output fifo_rd_en, host_data, host_data_valid, segment_ready, underflow_count,
               underflow_err, bytes_read, busy
    );

    modport slave (
        output stream_enable, stream_segment_threshold, fifo_empty, fifo_level, fifo_data,
               host_req, segment_ack, clear_errors, no_underflow_errors,
        input  fifo_rd_en, host_data, host_data_valid, segment_ready, underflow_count,
               underflow_err, bytes_read, busy
    );
endinterface

// File: rtl/adc_fifo_stream_sequencer.sv
// Streaming-mode controller for the ADC sample FIFO read port. Waits for a full
// segment to be buffered, announces it, pops exactly one segment in response to
// host byte requests, then waits for the host acknowledge before re-arming.
module adc_fifo_stream_sequencer #(
    parameter int unsigned pLEVEL_WIDTH  = 18,
    parameter int unsigned pTHRESH_WIDTH = 17
) (
    input  logic                         clk_usb,
    input  logic                         reset_i,
    adc_fifo_stream_sequencer_if.master  bus
);
    localparam int unsigned CmpW = (pLEVEL_WIDTH > pTHRESH_WIDTH) ? pLEVEL_WIDTH : pTHRESH_WIDTH;

    typedef enum logic [1:0] {StIdle, StWaitSeg, StReady, StDone} state_e;

    state_e                   state_q;
    logic [pTHRESH_WIDTH-1:0] seg_remaining_q;
    logic                     segment_ready_q;
    logic                     pop_q;
    logic                     underflow_q;
    logic [7:0]               underflow_count_q;
    logic                     underflow_err_q;
    logic [31:0]              bytes_read_q;

    logic [pTHRESH_WIDTH-1:0] thresh_eff;
    logic [CmpW-1:0]          level_ext;
    logic [CmpW-1:0]          thresh_ext;
    logic                     seg_full;
    logic                     pop;
    logic                     underflow;
    logic                     stream_start;

    // Threshold of zero means one-byte segments; compare at the wider of the two widths.
    always_comb begin
        thresh_eff = bus.stream_segment_threshold;
        if (bus.stream_segment_threshold == '0) begin
            thresh_eff = pTHRESH_WIDTH'(1);
        end
        level_ext  = CmpW'(bus.fifo_level);
        thresh_ext = CmpW'(thresh_eff);
        seg_full   = (level_ext >= thresh_ext);
    end

    // Pop only for a request in READY with data present; a request anywhere else
    // outside IDLE (or into an empty FIFO) is an underflow. Reset suppresses both.
    assign pop          = bus.host_req & (state_q == StReady) & ~bus.fifo_empty & ~reset_i;
    assign underflow    = bus.host_req & ~reset_i &
                          (((state_q == StReady) & bus.fifo_empty) |
                           (state_q == StWaitSeg) | (state_q == StDone));
    assign stream_start = (state_q == StIdle) & bus.stream_enable;

    // Segment FSM with registered segment_ready.
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_q         <= StIdle;
            seg_remaining_q <= '0;
            segment_ready_q <= 1'b0;
        end else if ((state_q != StIdle) && !bus.stream_enable) begin
            state_q         <= StIdle;
            segment_ready_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.stream_enable) begin
                        state_q <= StWaitSeg;
                    end
                end
                StWaitSeg: begin
                    if (seg_full) begin
                        state_q         <= StReady;
                        seg_remaining_q <= thresh_eff;
                        segment_ready_q <= 1'b1;
                    end
                end
                StReady: begin
                    if (pop) begin
                        seg_remaining_q <= seg_remaining_q - pTHRESH_WIDTH'(1);
                        if (seg_remaining_q == pTHRESH_WIDTH'(1)) begin
                            state_q         <= StDone;
                            segment_ready_q <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    // stream_enable is known high here; the drop case is handled above.
                    if (bus.segment_ack) begin
                        state_q <= StWaitSeg;
                    end
                end
                default: begin
                    state_q         <= StIdle;
                    segment_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Return-path strobes and status counters.
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            pop_q             <= 1'b0;
            underflow_q       <= 1'b0;
            underflow_count_q <= 8'h00;
            underflow_err_q   <= 1'b0;
            bytes_read_q      <= 32'h0;
        end else begin
            pop_q       <= pop;
            underflow_q <= underflow;

            if (stream_start) begin
                bytes_read_q <= 32'h0;
            end else if (pop) begin
                bytes_read_q <= bytes_read_q + 32'd1;
            end

            // Clear has priority over a coincident underflow.
            if (bus.clear_errors) begin
                underflow_count_q <= 8'h00;
                underflow_err_q   <= 1'b0;
            end else if (underflow) begin
                if (underflow_count_q != 8'hFF) begin
                    underflow_count_q <= underflow_count_q + 8'd1;
                end
                if (!bus.no_underflow_errors) begin
                    underflow_err_q <= 1'b1;
                end
            end
        end
    end

    // FIFO data arrives the cycle after the pop; underflows return 0x00.
    assign bus.fifo_rd_en      = pop;
    assign bus.host_data       = pop_q ? bus.fifo_data : 8'h00;
    assign bus.host_data_valid = pop_q | underflow_q;
    assign bus.segment_ready   = segment_ready_q;
    assign bus.underflow_count = underflow_count_q;
    assign bus.underflow_err   = underflow_err_q;
    assign bus.bytes_read      = bytes_read_q;
    assign bus.busy            = (state_q != StIdle);
endmodule
